// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, aluop encoding and funct3 values.
// Used by the issue controller, its decoder and the datapath ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        LDST   = 2'b00,
        BRANCH = 2'b01,
        RTYPE  = 2'b10,
        RSVD   = 2'b11
    } alu_op_e;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU and result bus of alu_issue_ctrl; the slave modport is the controller.
// Optional macro ALU_BRANCH_EN adds the res_taken signal.
interface alu_issue_ctrl_if #(parameter int WIDTH = 32);

    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_aluop;
    logic [2:0]       req_funct3;
    logic             req_funct7b5;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;

    logic [WIDTH-1:0] alu_in1;
    logic [WIDTH-1:0] alu_in2;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_zero;
    logic             res_illegal;
`ifdef ALU_BRANCH_EN
    logic             res_taken;

    modport master (
        output req_valid, req_aluop, req_funct3, req_funct7b5, req_a, req_b,
        input  req_ready,
        input  alu_in1, alu_in2, alu_control,
        output alu_result, alu_zero,
        input  res_valid, res_data, res_zero, res_illegal, res_taken,
        output res_ready
    );

    modport slave (
        input  req_valid, req_aluop, req_funct3, req_funct7b5, req_a, req_b,
        output req_ready,
        output alu_in1, alu_in2, alu_control,
        input  alu_result, alu_zero,
        output res_valid, res_data, res_zero, res_illegal, res_taken,
        input  res_ready
    );
`else
    modport master (
        output req_valid, req_aluop, req_funct3, req_funct7b5, req_a, req_b,
        input  req_ready,
        input  alu_in1, alu_in2, alu_control,
        output alu_result, alu_zero,
        input  res_valid, res_data, res_zero, res_illegal,
        output res_ready
    );

    modport slave (
        input  req_valid, req_aluop, req_funct3, req_funct7b5, req_a, req_b,
        output req_ready,
        output alu_in1, alu_in2, alu_control,
        input  alu_result, alu_zero,
        output res_valid, res_data, res_zero, res_illegal,
        input  res_ready
    );
`endif

endinterface

// File: rtl/alu_decode.sv
// Combinational aluop/funct decode to the 4-bit ALU control code.
// Illegal encodings are flagged and fall back to ADD so they still flow.
module alu_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control,
    output logic       illegal
);

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op_e'(aluop))
            LDST:   alu_control = ALU_ADD;
            BRANCH: alu_control = ALU_SUB;
            RTYPE: begin
                case (funct3)
                    F3_ADDSUB: alu_control = funct7b5 ? ALU_SUB : ALU_ADD;
                    F3_AND:    alu_control = ALU_AND;
                    F3_OR:     alu_control = ALU_OR;
                    default:   illegal     = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue/retire controller in front of the datapath ALU (latency 2).
// Optional macro ALU_BRANCH_EN adds branch-taken evaluation on res_taken.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst_n,
    alu_issue_ctrl_if.slave bus
);

    logic [3:0]       dec_control;
    logic             dec_illegal;

    logic             s1_valid;
    logic [3:0]       s1_control;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_illegal;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic             s2_zero;
    logic             s2_illegal;

    logic             s2_free;
    logic             s1_advance;
    logic             accept;

    alu_decode u_decode (
        .aluop       (bus.req_aluop),
        .funct3      (bus.req_funct3),
        .funct7b5    (bus.req_funct7b5),
        .alu_control (dec_control),
        .illegal     (dec_illegal)
    );

    // S1 may be refilled in the same cycle it hands off, so req_ready follows res_ready.
    assign s2_free       = !s2_valid || bus.res_ready;
    assign s1_advance    = s1_valid && s2_free;
    assign bus.req_ready = !s1_valid || s1_advance;
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_control <= 4'b0000;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_illegal <= 1'b0;
        end else if (accept) begin
            s1_valid   <= 1'b1;
            s1_control <= dec_control;
            s1_a       <= bus.req_a;
            s1_b       <= bus.req_b;
            s1_illegal <= dec_illegal;
        end else if (s1_advance) begin
            s1_valid   <= 1'b0;
        end
    end

    assign bus.alu_in1     = s1_valid ? s1_a : '0;
    assign bus.alu_in2     = s1_valid ? s1_b : '0;
    assign bus.alu_control = s1_valid ? s1_control : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_zero    <= 1'b0;
            s2_illegal <= 1'b0;
        end else if (s1_advance) begin
            s2_valid   <= 1'b1;
            s2_data    <= bus.alu_result;
            s2_zero    <= bus.alu_zero;
            s2_illegal <= s1_illegal;
        end else if (bus.res_ready) begin
            s2_valid   <= 1'b0;
        end
    end

    assign bus.res_valid   = s2_valid;
    assign bus.res_data    = s2_data;
    assign bus.res_zero    = s2_zero;
    assign bus.res_illegal = s2_illegal;

`ifdef ALU_BRANCH_EN
    alu_op_e s1_aluop;
    logic    s1_f3b0;
    logic    s2_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_aluop <= LDST;
            s1_f3b0  <= 1'b0;
        end else if (accept) begin
            s1_aluop <= alu_op_e'(bus.req_aluop);
            s1_f3b0  <= bus.req_funct3[0];
        end
    end

    // BEQ takes on zero, BNE on non-zero: funct3[0] inverts the zero flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_taken <= 1'b0;
        end else if (s1_advance) begin
            s2_taken <= (s1_aluop == BRANCH) ? (bus.alu_zero ^ s1_f3b0) : 1'b0;
        end
    end

    assign bus.res_taken = s2_taken;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural ALU on the datapath side.
// Build with ALU_BRANCH_EN defined to also check res_taken.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    localparam int WIDTH = 32;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             illegal;
        logic             taken;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    alu_issue_ctrl_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the datapath ALU.
    always_comb begin
        bus.alu_result = '0;
        case (bus.alu_control)
            ALU_AND: bus.alu_result = bus.alu_in1 & bus.alu_in2;
            ALU_OR:  bus.alu_result = bus.alu_in1 | bus.alu_in2;
            ALU_ADD: bus.alu_result = bus.alu_in1 + bus.alu_in2;
            ALU_SUB: bus.alu_result = bus.alu_in1 - bus.alu_in2;
            default: bus.alu_result = '0;
        endcase
        bus.alu_zero = (bus.alu_result == '0);
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Called right after a posedge; returns at the posedge where the request is taken.
    task automatic applyStimulus(input logic [1:0] aluop, input logic [2:0] f3, input logic f7,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] e_data, input logic e_zero,
                                 input logic e_ill, input logic e_taken);
        exp_t e;
        bit   done;
        #1;
        bus.req_valid    = 1'b1;
        bus.req_aluop    = aluop;
        bus.req_funct3   = f3;
        bus.req_funct7b5 = f7;
        bus.req_a        = a;
        bus.req_b        = b;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.req_ready) begin
                @(posedge clk);
                e.data    = e_data;
                e.zero    = e_zero;
                e.illegal = e_ill;
                e.taken   = e_taken;
                sb_q.push_back(e);
                done = 1'b1;
            end else begin
                @(posedge clk);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: req_ready stayed 0, expected 1");
        end
    endtask

    // Monitor: pops one expected result on every completed result handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.res_valid && bus.res_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result: got data 0x%0h, expected none",
                             bus.res_data);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("res_data", bus.res_data, e.data);
                    checkOutput("res_zero", WIDTH'(bus.res_zero), WIDTH'(e.zero));
                    checkOutput("res_illegal", WIDTH'(bus.res_illegal), WIDTH'(e.illegal));
`ifdef ALU_BRANCH_EN
                    checkOutput("res_taken", WIDTH'(bus.res_taken), WIDTH'(e.taken));
`endif
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, WIDTH'(bus.req_ready), 1);
        checkOutput({tag, "_res_valid"}, WIDTH'(bus.res_valid), 0);
        checkOutput({tag, "_res_data"}, bus.res_data, 0);
        checkOutput({tag, "_res_zero"}, WIDTH'(bus.res_zero), 0);
        checkOutput({tag, "_res_illegal"}, WIDTH'(bus.res_illegal), 0);
        checkOutput({tag, "_alu_in1"}, bus.alu_in1, 0);
        checkOutput({tag, "_alu_in2"}, bus.alu_in2, 0);
        checkOutput({tag, "_alu_control"}, WIDTH'(bus.alu_control), 0);
`ifdef ALU_BRANCH_EN
        checkOutput({tag, "_res_taken"}, WIDTH'(bus.res_taken), 0);
`endif
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_aluop    = 2'b00;
        bus.req_funct3   = 3'b000;
        bus.req_funct7b5 = 1'b0;
        bus.req_a        = '0;
        bus.req_b        = '0;
        bus.res_ready    = 1'b1;

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);

        // R-type ADD with latency checks on the ALU drive and the result.
        applyStimulus(2'b10, 3'b000, 1'b0, 5, 7, 12, 1'b0, 1'b0, 1'b0);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("add_alu_control", WIDTH'(bus.alu_control), WIDTH'(4'b0010));
        checkOutput("add_alu_in1", bus.alu_in1, 5);
        checkOutput("add_alu_in2", bus.alu_in2, 7);
        checkOutput("add_res_valid_n1", WIDTH'(bus.res_valid), 0);
        @(negedge clk);
        checkOutput("add_res_valid_n2", WIDTH'(bus.res_valid), 1);
        @(posedge clk);

        applyStimulus(2'b10, 3'b000, 1'b1, 9, 9, 0, 1'b1, 1'b0, 1'b0);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("sub_alu_control", WIDTH'(bus.alu_control), WIDTH'(4'b0110));
        @(posedge clk);

        // Back-to-back stream at full throughput.
        applyStimulus(2'b10, 3'b111, 1'b1, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 3'b110, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 3'b000, 1'b0, 3, 3, 0, 1'b1, 1'b0, 1'b1);
        applyStimulus(2'b01, 3'b001, 1'b0, 3, 3, 0, 1'b1, 1'b0, 1'b0);
        applyStimulus(2'b01, 3'b001, 1'b0, 3, 4, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(2'b11, 3'b000, 1'b0, 10, 20, 30, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b10, 3'b100, 1'b0, 100, 1, 101, 1'b0, 1'b1, 1'b0);
        #1 bus.req_valid = 1'b0;
        repeat (3) @(posedge clk);

        // Backpressure: two requests buffer, the third is held off.
        #1 bus.res_ready = 1'b0;
        applyStimulus(2'b10, 3'b000, 1'b0, 1, 2, 3, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b10, 3'b000, 1'b1, 10, 4, 6, 1'b0, 1'b0, 1'b0);
        #1;
        bus.req_valid    = 1'b1;
        bus.req_aluop    = 2'b10;
        bus.req_funct3   = 3'b110;
        bus.req_funct7b5 = 1'b0;
        bus.req_a        = 8;
        bus.req_b        = 1;
        @(negedge clk);
        checkOutput("bp_req_ready_low", WIDTH'(bus.req_ready), 0);
        checkOutput("bp_res_valid", WIDTH'(bus.res_valid), 1);
        @(negedge clk);
        checkOutput("bp_req_ready_held", WIDTH'(bus.req_ready), 0);
        checkOutput("bp_res_data_held", bus.res_data, 3);
        @(posedge clk);
        #1 bus.res_ready = 1'b1;
        applyStimulus(2'b10, 3'b110, 1'b0, 8, 1, 9, 1'b0, 1'b0, 1'b0);
        #1 bus.req_valid = 1'b0;
        repeat (4) @(posedge clk);
        checkOutput("bp_scoreboard_empty", WIDTH'(sb_q.size()), 0);

        // Reset with two requests in flight.
        #1 bus.res_ready = 1'b0;
        applyStimulus(2'b00, 3'b000, 1'b0, 1, 1, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(2'b00, 3'b000, 1'b0, 2, 2, 4, 1'b0, 1'b0, 1'b0);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        checkOutput("pre_rst_res_valid", WIDTH'(bus.res_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("midrst");
        sb_q.delete();
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("post_rst_no_stale", WIDTH'(bus.res_valid), 0);
        end

        // Normal operation resumes after reset.
        @(posedge clk);
        applyStimulus(2'b10, 3'b000, 1'b0, 40, 2, 42, 1'b0, 1'b0, 1'b0);
        #1 bus.req_valid = 1'b0;
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        checkOutput("final_scoreboard_empty", WIDTH'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Pipelined issue and retire controller that drives the 32-bit datapath ALU. It sits between the decode stage and the ALU.

- Accepts decoded instruction fields and operands over a valid/ready handshake.
- Translates ALUOp/funct into the 4-bit ALU control code and drives the ALU from a registered stage.
- Captures the ALU result and zero flag into a retire register, presented downstream with its own valid/ready handshake.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept request
- req_aluop  input  2  00 load/store, 01 branch, 10 R-type, 11 reserved
- req_funct3  input  3  funct3 field
- req_funct7b5  input  1  bit 5 of funct7
- req_a, req_b  input  WIDTH  operands
- alu_in1, alu_in2  output  WIDTH  ALU operands
- alu_control  output  4  ALU operation code
- alu_result  input  WIDTH  ALU result (combinational from alu_in*/alu_control)
- alu_zero  input  1  ALU zero flag
- res_valid  output  1  result present
- res_ready  input  1  downstream accepts result
- res_data  output  WIDTH  captured result
- res_zero  output  1  captured zero flag
- res_illegal  output  1  request decoded as illegal
- res_taken  output  1  branch taken; present only with ALU_BRANCH_EN

## Operation
Decode (combinational, from request fields):
- aluop 00 → ADD 4'b0010.
- aluop 01 → SUB 4'b0110.
- aluop 10:
  - funct3 000, funct7b5 0 → ADD.
  - funct3 000, funct7b5 1 → SUB.
  - funct3 111 → AND 4'b0000.
  - funct3 110 → OR 4'b0001.
  - any other funct3 → illegal.
- aluop 11 → illegal.
- Illegal requests:
  - are issued as ADD;
  - still flow through the pipeline;
  - retire with res_illegal=1.

Stage S1 (issue register):
- Holds the control code, operands, illegal bit, aluop and funct3[0].
- Drives alu_in1/alu_in2/alu_control while s1_valid.
- When S1 is empty, drives operands 0 and alu_control 4'b0000.

Stage S2 (retire register):
- Captures alu_result, alu_zero, the illegal bit and, with the macro, the taken bit.

Flow control:
- S2 frees when !res_valid or res_ready.
- S1 advances into S2 when s1_valid and S2 frees.
- req_ready = !s1_valid or S1 advances. This is combinational from res_ready, with no bubble.
- Simultaneous accept and advance: S1 loads the new request in the same cycle as S2 captures the old one.
- res_data, res_zero and res_illegal are held stable while res_valid && !res_ready.

Reset (asynchronous, rst_n low), mid-transfer included:
- S1 and S2 valid bits clear and data registers clear.
- Outputs: req_ready=1, res_valid=0, res_data=0, res_zero=0, res_illegal=0, res_taken=0, alu_* = 0.
- In-flight requests are dropped.

## Timing
- Request accepted in cycle N → ALU driven in N+1 → res_valid in N+2 (latency 2).
- Sustained throughput is 1 request per cycle while res_ready=1.
- With res_ready low, at most 2 requests are buffered (S1 and S2). req_ready falls in the cycle both are full.
- The ALU path is a single combinational cycle from S1 outputs to S2 capture; no multicycle paths.

## Configuration
- ALU_BRANCH_EN defined:
  - res_taken port exists.
  - For aluop 01: taken = alu_zero XOR funct3[0] (BEQ when 000, BNE when 001).
  - For any other aluop: taken = 0.
- ALU_BRANCH_EN undefined:
  - res_taken port and taken logic are absent.
  - funct3 is ignored for aluop 01.

## Structure
- Shared package alu_pkg holds:
  - ALU code constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB;
  - aluop enum (LDST, BRANCH, RTYPE, RSVD);
  - funct3 constants.
- The existing ALU uses the same package constants.
- Sub-module alu_decode holds the combinational field-to-control decode plus the illegal flag. alu_issue_ctrl instantiates it on the request inputs.
- The ALU itself is instantiated outside, at the datapath level.

## Test plan
- R-type ADD: a=5, b=7, funct3 000, funct7b5 0 → alu_control 0010 in N+1; res_data=12, res_zero=0 in N+2.
- R-type SUB: a=9, b=9 → alu_control 0110; res_data=0, res_zero=1.
- Branch with ALU_BRANCH_EN:
  - BEQ a=3, b=3 → res_taken=1;
  - BNE a=3, b=3 → res_taken=0.
- Backpressure:
  - With res_ready=0, issue 3 back-to-back requests → req_ready drops after the 2nd.
  - Raise res_ready → results retire in order with no loss or duplication.
- Illegal: aluop 11, or aluop 10 with funct3 100 → res_illegal=1, res_data=a+b.
- Reset: assert rst_n low with 2 requests in flight → all outputs at reset values immediately; after release, no stale res_valid.
